// File: rtl/poly_pointwise_mul_if.sv
// Coefficient stream bundle for poly_pointwise_mul: paired A/B input stream
// and product output stream, both valid/ready.
interface poly_pointwise_mul_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a_coef;
    logic [31:0] b_coef;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] c_coef;
    logic        out_last;

    modport master (
        output in_valid, a_coef, b_coef, out_ready,
        input  in_ready, out_valid, c_coef, out_last
    );

    modport slave (
        input  in_valid, a_coef, b_coef, out_ready,
        output in_ready, out_valid, c_coef, out_last
    );
endinterface

// File: rtl/poly_pointwise_mul.sv
// NTT-domain pointwise product c[i] = a[i]*b[i] mod Q over N coefficients.
// Define PWM_INPUT_REDUCE_EN to add a leading stage canonicalising signed inputs.
module poly_pointwise_mul #(
    parameter int Q = 8380417,
    parameter int N = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    poly_pointwise_mul_if.slave  bus,
    output logic                 busy,
    output logic                 done
);
    localparam int CW = $clog2(N + 1);
`ifdef PWM_INPUT_REDUCE_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   in_cnt_q, in_cnt_d;
    logic [CW-1:0]   out_cnt_q, out_cnt_d;
    logic [LAT-1:0]  vld_q;
    logic [63:0]     prod_q;
    logic [31:0]     red_q;
    logic [31:0]     c_q;
    logic [31:0]     mul_a, mul_b;
    logic            stall, acc, out_hs;

    // A held output freezes every stage, so nothing behind it can be lost.
    assign stall         = vld_q[LAT-1] && !bus.out_ready;
    assign bus.in_ready  = (state_q == RUN) && (in_cnt_q < CW'(N)) && !stall;
    assign acc           = bus.in_valid && bus.in_ready;
    assign out_hs        = vld_q[LAT-1] && bus.out_ready;
    assign bus.out_valid = vld_q[LAT-1];
    assign bus.c_coef    = c_q;
    assign bus.out_last  = vld_q[LAT-1] && (out_cnt_q == CW'(N - 1));
    assign busy          = (state_q != IDLE);
    assign done          = (state_q == DONE);

`ifdef PWM_INPUT_REDUCE_EN
    logic [31:0] ca_q, cb_q;

    // Signed % truncates toward zero, so a negative remainder needs one +Q.
    function automatic logic [31:0] canon(input logic [31:0] x);
        logic signed [31:0] r;
        r = $signed(x) % Q;
        if (r < 0)
            r = r + Q;
        return $unsigned(r);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ca_q <= '0;
            cb_q <= '0;
        end else if (!stall) begin
            ca_q <= canon(bus.a_coef);
            cb_q <= canon(bus.b_coef);
        end
    end

    assign mul_a = ca_q;
    assign mul_b = cb_q;
`else
    assign mul_a = bus.a_coef;
    assign mul_b = bus.b_coef;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q  <= '0;
            prod_q <= '0;
            red_q  <= '0;
            c_q    <= '0;
        end else if (!stall) begin
            vld_q  <= {vld_q[LAT-2:0], acc};
            prod_q <= 64'(mul_a) * 64'(mul_b);
            red_q  <= 32'(prod_q % 64'(Q));
            if (vld_q[LAT-2])
                c_q <= red_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = RUN;
                    in_cnt_d  = '0;
                    out_cnt_d = '0;
                end
            end
            RUN: begin
                if (acc) begin
                    in_cnt_d = in_cnt_q + CW'(1);
                    if (in_cnt_q == CW'(N - 1))
                        state_d = DRAIN;
                end
                if (out_hs)
                    out_cnt_d = out_cnt_q + CW'(1);
            end
            DRAIN: begin
                if (out_hs) begin
                    out_cnt_d = out_cnt_q + CW'(1);
                    if (out_cnt_q == CW'(N - 1))
                        state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: doc/poly_pointwise_mul.md
POLY_POINTWISE_MUL -- requirements
Module: poly_pointwise_mul

Interface
REQ-001 SHALL have parameter Q, default 8380417, coefficient modulus.
REQ-002 SHALL have parameter N, default 256, coefficients per polynomial.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  begin one polynomial product; sampled in IDLE only.
REQ-006 SHALL have port in_valid  input  1  a_coef/b_coef pair valid.
REQ-007 SHALL have port in_ready  output  1  block accepts pair this cycle.
REQ-008 SHALL have port a_coef  input  32  signed NTT-domain coefficient of operand A.
REQ-009 SHALL have port b_coef  input  32  signed NTT-domain coefficient of operand B.
REQ-010 SHALL have port out_valid  output  1  c_coef valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts c_coef.
REQ-012 SHALL have port c_coef  output  32  signed product coefficient, range [0,Q).
REQ-013 SHALL have port out_last  output  1  high with coefficient index N-1.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-015 SHALL have port done  output  1  one-cycle pulse after the last output handshake.

Function
REQ-016 SHALL compute c[i] = (a[i]*b[i]) mod Q, in the order received, for i = 0..N-1.
REQ-017 SHALL form the product at least 46 bits wide, reduce it to [0,Q), and never output Q or a negative value.
REQ-018 SHALL implement FSM states IDLE, RUN, DRAIN, DONE.
REQ-019 IDLE -> RUN on start; input counter and output counter cleared.
REQ-020 RUN -> DRAIN when the Nth input handshake (in_valid && in_ready) completes.
REQ-021 DRAIN -> DONE when the Nth output handshake (out_valid && out_ready) completes; done asserted in DONE for one cycle; DONE -> IDLE next cycle.
REQ-022 in_ready SHALL be high only in RUN, with input count < N, and no pipeline stall.
REQ-023 Pipeline SHALL be 3 stages (multiply, reduce, output register); without stalls, the pair accepted at cycle k appears on c_coef with out_valid at cycle k+3.
REQ-024 Stall: out_valid && !out_ready SHALL freeze all stages and hold c_coef, out_last stable; no data lost or duplicated.
REQ-025 Sustained throughput SHALL be one coefficient per cycle when in_valid and out_ready are held high.
REQ-026 start SHALL be ignored outside IDLE; start and the last output handshake in the same cycle SHALL not restart the block.
REQ-027 Gaps in in_valid SHALL insert bubbles; out_valid SHALL be low for bubble slots.
REQ-028 Output counter SHALL count 0..N-1 and out_last SHALL be high exactly when it equals N-1.

Reset
REQ-029 On rst: state IDLE, counters 0, pipeline valid bits 0; in_ready, out_valid, out_last, busy, done = 0; c_coef = 0.
REQ-030 rst mid-operation SHALL abort the product immediately; no out_valid or done follows until a new start.

Configuration
REQ-031 Macro PWM_INPUT_REDUCE_EN defined: a_coef, b_coef SHALL first be canonicalised to ((x mod Q)+Q) mod Q in an added leading stage; latency becomes 4; any signed 32-bit input is legal.
REQ-032 Macro PWM_INPUT_REDUCE_EN undefined: inputs SHALL be used as-is and are required to lie in [0,Q); latency 3; out-of-range inputs give undefined results.

Verification
REQ-033 start, stream a=i, b=1 for i=0..255, out_ready=1 -> c[i]=i, first out_valid 3 cycles after first accept, out_last at i=255, done one cycle after.
REQ-034 a=8380416, b=8380416 -> c=1; a=2, b=4190209 -> c=1; a=0, b=5000000 -> c=0.
REQ-035 out_ready toggled 1/0 every cycle during full stream -> all 256 results exact, in order, c_coef stable during each stall.
REQ-036 rst asserted after 100 inputs, then new start and full stream -> no stale outputs; 256 correct results.
REQ-037 PWM_INPUT_REDUCE_EN defined: a=-1 (0xFFFFFFFF), b=5 -> c=8380412; a=8380418, b=3 -> c=3; latency 4.
REQ-038 start pulsed during RUN and DRAIN -> ignored; exactly 256 outputs and one done pulse.
